// File: rtl/fsm_reels_n.sv
// fsm_reels_n: N-reel stop-and-match game controller.
// Stops reels from key edges or timeout, then scores the latched letters.
module fsm_reels_n #(
   parameter int N_REELS = 4,
   parameter int LW      = 4,
   parameter int TIMEOUT = 0,
   parameter int LIVES   = 3,
   parameter int WIN_PTS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REELS-1:0]    key,
   input  logic [N_REELS*LW-1:0] letters,
   output logic [N_REELS-1:0]    stop_flag,
   output logic [19:0]           message,
   output logic                  end_flag,
   output logic                  game_over,
   output logic [7:0]            score,
   output logic [3:0]            lives_left
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int IW = (N_REELS > 1) ? $clog2(N_REELS) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IW-1:0] I_LAST = IW'(N_REELS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SPIN, S_EVAL, S_GOOD, S_LOSE, S_OVER
   } state_t;

   state_t state, state_n;

   logic [IW-1:0]      idx, idx_n;
   logic [TW-1:0]      timer, timer_n;
   logic [N_REELS-1:0] key_q;
   logic [N_REELS-1:0] rise;
   logic [N_REELS-1:0] rise_rev;
   logic [N_REELS-1:0] flag_n;
   logic [LW-1:0]      lat   [N_REELS];
   logic [LW-1:0]      lat_n [N_REELS];
   logic [7:0]         score_n;
   logic [3:0]         lives_n;
   logic [19:0]        msg_n;
   logic [8:0]         sum;
   logic               expired;
   logic               stop_key;
   logic               all_eq;
   logic               restart;

   assign rise      = key & ~key_q;
   assign restart   = key[0] & key[1];
   assign sum       = {1'b0, score} + 9'(WIN_PTS);
   assign end_flag  = (state == S_GOOD) || (state == S_LOSE) ||
                      (state == S_OVER);
   assign game_over = (state == S_OVER);

   // Reverse key edges so reel idx maps to key N_REELS-1-idx.
   always_comb begin
      rise_rev = '0;
      for (int k = 0; k < N_REELS; k++)
         rise_rev[k] = rise[N_REELS-1-k];
   end

   // Stop-event and match qualifiers for the current cycle.
   always_comb begin
      expired  = (TIMEOUT > 0) && (state == S_SPIN) && (timer == T_LAST);
      stop_key = rise_rev[idx];
      all_eq   = 1'b1;
      for (int k = 1; k < N_REELS; k++)
         if (lat[k] != lat[0]) all_eq = 1'b0;
   end

   // Next-state and datapath updates for the game sequence.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      timer_n = timer;
      flag_n  = stop_flag;
      lat_n   = lat;
      score_n = score;
      lives_n = lives_left;
      case (state)
         S_IDLE: begin
            timer_n = '0;
            if (rise[N_REELS-1]) begin
               lat_n[0]  = letters[0 +: LW];
               flag_n[0] = 1'b0;
               idx_n     = IW'(1);
               state_n   = (N_REELS > 1) ? S_SPIN : S_EVAL;
            end
         end
         S_SPIN: begin
            if (stop_key || expired) begin
               lat_n[idx]  = letters[int'(idx)*LW +: LW];
               flag_n[idx] = 1'b0;
               timer_n     = '0;
               if (idx == I_LAST) begin
                  idx_n   = '0;
                  state_n = S_EVAL;
               end else begin
                  idx_n = idx + IW'(1);
               end
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         S_EVAL: begin
            idx_n   = '0;
            timer_n = '0;
            if (all_eq) begin
               state_n = S_GOOD;
               score_n = (sum > 9'd255) ? 8'hFF : sum[7:0];
            end else begin
               state_n = (lives_left > 4'd1) ? S_LOSE : S_OVER;
               lives_n = (lives_left == 4'd0) ? 4'd0 : lives_left - 4'd1;
            end
         end
         S_GOOD, S_LOSE: begin
            if (restart) begin
               state_n = S_IDLE;
               idx_n   = '0;
               timer_n = '0;
               flag_n  = '1;
               for (int k = 0; k < N_REELS; k++) lat_n[k] = '0;
            end
         end
         S_OVER: begin
            if (restart) begin
               state_n = S_IDLE;
               idx_n   = '0;
               timer_n = '0;
               flag_n  = '1;
               score_n = '0;
               lives_n = 4'(LIVES);
               for (int k = 0; k < N_REELS; k++) lat_n[k] = '0;
            end
         end
         default: begin
            state_n = S_IDLE;
            idx_n   = '0;
            timer_n = '0;
            flag_n  = '1;
            for (int k = 0; k < N_REELS; k++) lat_n[k] = '0;
         end
      endcase
   end

   // Display codes follow the state register, one cycle behind entry.
   always_comb begin
      msg_n = '0;
      case (state)
         S_GOOD:  msg_n = {5'h12, 5'h11, 5'h11, 5'h10};
         S_LOSE:  msg_n = {5'h15, 5'h14, 5'h11, 5'h13};
         S_OVER:  msg_n = {5'h17, 5'h15, 5'h16, 5'h11};
         default: msg_n = '0;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= '0;
         timer      <= '0;
         key_q      <= '0;
         stop_flag  <= '1;
         message    <= '0;
         score      <= '0;
         lives_left <= 4'(LIVES);
         for (int k = 0; k < N_REELS; k++) lat[k] <= '0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         timer      <= timer_n;
         key_q      <= key;
         stop_flag  <= flag_n;
         message    <= msg_n;
         score      <= score_n;
         lives_left <= lives_n;
         for (int k = 0; k < N_REELS; k++) lat[k] <= lat_n[k];
      end
   end

endmodule

// File: tb/tb_fsm_reels_n.sv
// tb_fsm_reels_n: directed and random checks of fsm_reels_n.
// Two instances (no timeout / timeout 10) share inputs and a game model.
module tb_fsm_reels_n;

   localparam int P_IDLE = 0, P_SPIN = 1, P_EVAL = 2;
   localparam int P_GOOD = 3, P_LOSE = 4, P_OVER = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  key;
   logic [15:0] letters;
   logic [3:0]  sf0, sf1, lv0, lv1;
   logic [19:0] m0, m1;
   logic        ef0, ef1, go0, go1;
   logic [7:0]  sc0, sc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fsm_reels_n #(.N_REELS(4), .LW(4), .TIMEOUT(0), .LIVES(3),
                 .WIN_PTS(2)) u0 (
      .clk(clk), .reset(reset), .key(key), .letters(letters),
      .stop_flag(sf0), .message(m0), .end_flag(ef0),
      .game_over(go0), .score(sc0), .lives_left(lv0));

   fsm_reels_n #(.N_REELS(4), .LW(4), .TIMEOUT(10), .LIVES(3),
                 .WIN_PTS(2)) u1 (
      .clk(clk), .reset(reset), .key(key), .letters(letters),
      .stop_flag(sf1), .message(m1), .end_flag(ef1),
      .game_over(go1), .score(sc1), .lives_left(lv1));

   // Game model: phase, reels stopped so far, letters grabbed.
   int ph [2];
   int nst [2];
   int since [2];
   int sc [2];
   int lv [2];
   int shown [2];
   int grab [2][4];
   int tmo [2] = '{0, 10};
   logic [3:0] kprev;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] msg_of(int p);
      case (p)
         P_GOOD:  return {5'h12, 5'h11, 5'h11, 5'h10};
         P_LOSE:  return {5'h15, 5'h14, 5'h11, 5'h13};
         P_OVER:  return {5'h17, 5'h15, 5'h16, 5'h11};
         default: return 20'h0;
      endcase
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         ph[i] = P_IDLE; nst[i] = 0; since[i] = 0;
         sc[i] = 0; lv[i] = 3; shown[i] = P_IDLE;
         for (int k = 0; k < 4; k++) grab[i][k] = 0;
      end
      kprev = 4'h0;
   endtask

   task automatic m_step(int i, logic [3:0] rise);
      bit hit;
      bit same;
      shown[i] = ph[i];
      case (ph[i])
         P_IDLE: if (rise[3]) begin
            grab[i][0] = int'(letters[3:0]);
            nst[i] = 1; since[i] = 0; ph[i] = P_SPIN;
         end
         P_SPIN: begin
            hit = rise[3-nst[i]] ||
                  (tmo[i] > 0 && since[i] == tmo[i] - 1);
            if (hit) begin
               grab[i][nst[i]] = int'(letters[nst[i]*4 +: 4]);
               nst[i]++; since[i] = 0;
               if (nst[i] == 4) ph[i] = P_EVAL;
            end else begin
               since[i]++;
            end
         end
         P_EVAL: begin
            same = 1;
            for (int k = 1; k < 4; k++)
               if (grab[i][k] != grab[i][0]) same = 0;
            if (same) begin
               ph[i] = P_GOOD;
               sc[i] = (sc[i] + 2 > 255) ? 255 : sc[i] + 2;
            end else begin
               ph[i] = (lv[i] > 1) ? P_LOSE : P_OVER;
               lv[i] = (lv[i] > 0) ? lv[i] - 1 : 0;
            end
         end
         default: if (key[0] && key[1]) begin
            if (ph[i] == P_OVER) begin sc[i] = 0; lv[i] = 3; end
            ph[i] = P_IDLE; nst[i] = 0;
            for (int k = 0; k < 4; k++) grab[i][k] = 0;
         end
      endcase
   endtask

   task automatic compare();
      logic [3:0] f;
      f = 4'hF; f = f << nst[0];
      chk("sf0", 32'(sf0), 32'(f));
      chk("msg0", 32'(m0), 32'(msg_of(shown[0])));
      chk("end0", 32'(ef0), 32'(ph[0] >= P_GOOD));
      chk("over0", 32'(go0), 32'(ph[0] == P_OVER));
      chk("score0", 32'(sc0), 32'(sc[0]));
      chk("lives0", 32'(lv0), 32'(lv[0]));
      f = 4'hF; f = f << nst[1];
      chk("sf1", 32'(sf1), 32'(f));
      chk("msg1", 32'(m1), 32'(msg_of(shown[1])));
      chk("end1", 32'(ef1), 32'(ph[1] >= P_GOOD));
      chk("over1", 32'(go1), 32'(ph[1] == P_OVER));
      chk("score1", 32'(sc1), 32'(sc[1]));
      chk("lives1", 32'(lv1), 32'(lv[1]));
   endtask

   // Inputs are set at a falling edge; model the next rising edge.
   task automatic step();
      logic [3:0] rise;
      if (reset) begin
         m_reset();
      end else begin
         rise = key & ~kprev;
         m_step(0, rise);
         m_step(1, rise);
         kprev = key;
      end
      @(negedge clk);
      compare();
   endtask

   task automatic press(logic [3:0] k, int gap);
      key = k; step();
      key = 4'h0;
      repeat (gap) step();
   endtask

   task automatic restart();
      key = 4'b0011; step();
      key = 4'h0; step();
   endtask

   task automatic full_game(int gap);
      press(4'b1000, gap); press(4'b0100, gap);
      press(4'b0010, gap); press(4'b0001, gap);
   endtask

   logic [3:0] base;

   initial begin
      reset = 1'b1; key = 4'h0; letters = 16'h0;
      m_reset();
      @(negedge clk); @(negedge clk);
      compare();
      chk("rst_sf", 32'(sf0), 32'hF);
      chk("rst_lives", 32'(lv0), 32'd3);
      reset = 1'b0;
      step();

      // Full match with keys spaced five cycles apart.
      letters = {4{4'h7}};
      press(4'b1000, 4);
      chk("t1_sf_first", 32'(sf0), 32'hE);
      press(4'b0100, 4); press(4'b0010, 4); press(4'b0001, 4);
      chk("t1_msg", 32'(m0), 32'({5'h12, 5'h11, 5'h11, 5'h10}));
      chk("t1_score", 32'(sc0), 32'd2);
      chk("t1_lives", 32'(lv0), 32'd3);
      chk("t1_end", 32'(ef0), 32'd1);
      restart();
      chk("t1_restart_sf", 32'(sf0), 32'hF);

      // Letters change after two reels stop: latched values decide.
      press(4'b1000, 4); press(4'b0100, 4);
      letters = {4{4'h3}};
      press(4'b0010, 4); press(4'b0001, 4);
      chk("t2_lives", 32'(lv0), 32'd2);
      chk("t2_score", 32'(sc0), 32'd2);
      chk("t2_over", 32'(go0), 32'd0);
      restart();

      // Three losses from reset lead to OVER.
      reset = 1'b1; step(); reset = 1'b0; step();
      for (int g = 0; g < 3; g++) begin
         letters = {4'h5, 4'h7, 4'h7, 4'h7};
         full_game(4);
         chk("t3_lives", 32'(lv0), 32'(2 - g));
         if (g < 2) restart();
      end
      chk("t3_over", 32'(go0), 32'd1);
      chk("t3_msg", 32'(m0), 32'({5'h17, 5'h15, 5'h16, 5'h11}));
      restart();
      chk("t3_lives_back", 32'(lv0), 32'd3);
      chk("t3_score_clr", 32'(sc0), 32'd0);

      // Timeout auto-stop, with a key edge on the expiry cycle.
      letters = {4{4'h7}};
      press(4'b1000, 9);
      key = 4'b0100; step();
      chk("t4_one_stop", 32'(sf1), 32'hC);
      key = 4'h0;
      repeat (15) step();
      chk("t4_auto", 32'(sf1), 32'h8);
      chk("t4_no_tmo", 32'(sf0), 32'hC);
      press(4'b0010, 4); press(4'b0001, 6);
      restart();

      // Wrong keys ignored; a held key stops only one reel.
      press(4'b1000, 4);
      press(4'b1001, 4);
      chk("t5_wrong", 32'(sf0), 32'hE);
      key = 4'b0100;
      repeat (20) step();
      key = 4'h0; step();
      chk("t5_held", 32'(sf0), 32'hC);
      press(4'b0010, 4); press(4'b0001, 6);
      restart();

      // Reset in the middle of a spin.
      press(4'b1000, 3); press(4'b0100, 3);
      reset = 1'b1; step();
      chk("t6_sf", 32'(sf0), 32'hF);
      chk("t6_score", 32'(sc0), 32'd0);
      reset = 1'b0; step();
      full_game(4);
      chk("t6_score_win", 32'(sc0), 32'd2);
      restart();

      // Random keys, letters and occasional resets.
      base = 4'h7;
      for (int n = 0; n < 4000; n++) begin
         for (int b = 0; b < 4; b++)
            key[b] = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 19) == 0)
            base = ($urandom_range(0, 1) == 1) ? 4'h7 : 4'h3;
         for (int k = 0; k < 4; k++)
            letters[k*4 +: 4] = ($urandom_range(0, 15) == 0) ?
                                4'($urandom) : base;
         reset = ($urandom_range(0, 599) == 0);
         step();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
